// File: rtl/batcharger_controller_gen2.sv
// Battery charge controller: sequences trickle, constant-current and constant-voltage charging
// with debounced threshold crossings, temperature-fault pause and a scaled charge timer.
module batcharger_controller_gen2 #(
   parameter int W        = 8,
   parameter int TSHIFT   = 8,
   parameter int DEBOUNCE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         vtok,
   input  logic [W-1:0] vbat,
   input  logic [W-1:0] ibat,
   input  logic [W-1:0] tbat,
   input  logic [W-1:0] vcutoff,
   input  logic [W-1:0] vpreset,
   input  logic [W-1:0] vrecharge,
   input  logic [W-1:0] tempmin,
   input  logic [W-1:0] tempmax,
   input  logic [W-1:0] tmax,
   input  logic [W-1:0] iend,
   output logic         tc,
   output logic         cc,
   output logic         cv,
   output logic         imonen,
   output logic         vmonen,
   output logic         tmonen,
   output logic [2:0]   state,
   output logic         done,
   output logic         timeout
);

   localparam int TW = W + TSHIFT;
   localparam int CW = $clog2(DEBOUNCE + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      TC    = 3'd2,
      CC    = 3'd3,
      CV    = 3'd4,
      ENDST = 3'd5,
      FAULT = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   db_cnt_q, db_cnt_d, db_eff;
   logic [1:0]      db_id_q, db_id_d, cond_id;
   state_t          cond_tgt;
   logic [TW-1:0]   timer_q, timer_d, timer_lim;
   logic            timeout_q, timeout_d;
   logic            tok, tmo_hit, fire, active;

   assign tok       = (tbat >= tempmin) && (tbat <= tempmax);
   assign timer_lim = {tmax, {TSHIFT{1'b0}}} - TW'(1);
   assign tmo_hit   = (tmax != '0) && (timer_q == timer_lim);
   assign active    = (state_q == TC) || (state_q == CC) || (state_q == CV);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         db_cnt_q  <= '0;
         db_id_q   <= '0;
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         db_cnt_q  <= db_cnt_d;
         db_id_q   <= db_id_d;
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
      end
   end

   // The debounce counter tracks only the highest-priority exit condition (cond_id);
   // a different condition taking over restarts the count from zero.
   always_comb begin
      cond_id   = 2'd0;
      cond_tgt  = state_q;
      state_d   = state_q;
      timeout_d = timeout_q;
      timer_d   = timer_q;
      case (state_q)
         WAIT: if (vtok && tok) begin
            cond_id  = 2'd1;
            cond_tgt = (vbat < vcutoff) ? TC : ((vbat < vpreset) ? CC : CV);
         end
         TC: if (!tok) begin cond_id = 2'd1; cond_tgt = FAULT; end
             else if (vbat >= vcutoff) begin cond_id = 2'd2; cond_tgt = CC; end
         CC: if (!tok) begin cond_id = 2'd1; cond_tgt = FAULT; end
             else if (vbat >= vpreset) begin cond_id = 2'd2; cond_tgt = CV; end
         CV: if (!tok) begin cond_id = 2'd1; cond_tgt = FAULT; end
             else if (ibat < iend) begin cond_id = 2'd2; cond_tgt = ENDST; end
         ENDST: if (vbat < vcutoff) begin cond_id = 2'd1; cond_tgt = TC; end
                else if (vbat < vrecharge) begin cond_id = 2'd2; cond_tgt = CC; end
         FAULT: if (tok) begin cond_id = 2'd1; cond_tgt = WAIT; end
         default: ;
      endcase

      db_eff = (cond_id == db_id_q) ? db_cnt_q : '0;
      fire   = (cond_id != 2'd0) && (db_eff == CW'(DEBOUNCE - 1));

      if (!en)
         state_d = IDLE;
      else if (state_q == IDLE) begin
         if (vtok) state_d = WAIT;
      end else if (!vtok && state_q != WAIT)
         state_d = WAIT;
      else if (fire && cond_tgt == FAULT)
         state_d = FAULT;
      else if (active && tmo_hit) begin
         state_d   = ENDST;
         timeout_d = 1'b1;
      end else if (fire)
         state_d = cond_tgt;

      if (state_d != state_q || cond_id == 2'd0) begin
         db_cnt_d = '0;
         db_id_d  = '0;
      end else begin
         db_cnt_d = db_eff + CW'(1);
         db_id_d  = cond_id;
      end

      if ((state_d == TC || state_d == CC) && state_d != state_q)
         timeout_d = 1'b0;

      // Timer restarts on every fresh charge start, saturates instead of wrapping.
      if (state_q == IDLE)
         timer_d = '0;
      else if ((state_q == WAIT || state_q == ENDST) && state_d != state_q &&
               (state_d == TC || state_d == CC || state_d == CV))
         timer_d = '0;
      else if (active && timer_q != '1)
         timer_d = timer_q + TW'(1);
   end

   assign tc      = (state_q == TC);
   assign cc      = (state_q == CC);
   assign cv      = (state_q == CV);
   assign imonen  = (state_q == CC) || (state_q == CV);
   assign vmonen  = (state_q != IDLE);
   assign tmonen  = (state_q != IDLE);
   assign done    = (state_q == ENDST);
   assign timeout = timeout_q;
   assign state   = state_q;

endmodule
